text_reader: RTL
================

Name: text_reader

Overview:
- Read side of the 40x15 text buffer; the keyboard writer fills the same buffer.
- Takes the VGA pixel position from the sync generator and converts it to a cell address (col + row*40, range 0..599).
- Issues reads on the buffer's read port and returns the character code aligned with delayed sync, blanking and glyph-offset signals, ready for the glyph ROM / pixel shader.

Parameters:
- COLS, 40, character columns per line
- ROWS, 15, character lines per screen
- CELL_W, 16, pixels per cell horizontally (power of two)
- CELL_H, 32, pixels per cell vertically (power of two)
- MEM_LAT, 1, read latency of buffer in cycles (1..3)
- AW, 10, buffer address width
- DW, 10, character code width

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- pixel_x  in  10  current pixel column from sync generator
- pixel_y  in  10  current pixel line from sync generator
- video_on  in  1  visible-area flag
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- address  out  AW  buffer read address
- rd_en  out  1  buffer read strobe
- rd_data_mem  in  DW  buffer read data, valid MEM_LAT cycles after rd_en
- char_code  out  DW  character of the current cell
- char_valid  out  1  current pixel lies inside the text grid
- glyph_x  out  4  pixel_x mod CELL_W, delayed
- glyph_y  out  5  pixel_y mod CELL_H, delayed
- video_on_o  out  1  delayed video_on
- hsync_o  out  1  delayed hsync_in
- vsync_o  out  1  delayed vsync_in

Behaviour:
- **Reset (rst=0, async):**
  - address=0, rd_en=0, char_code=0, char_valid=0, glyph_x=0, glyph_y=0, video_on_o=0.
  - hsync_o=1, vsync_o=1 (inactive).
  - All pipeline stages cleared; the last-fetched-cell tracker is invalidated.
- **Stage S0 (cycle t):** sample inputs.
  - col = pixel_x >> log2(CELL_W), row = pixel_y >> log2(CELL_H).
  - in_grid = video_on & col<COLS & row<ROWS.
- **Stage S1 (t+1):** address <= col + row*COLS, computed at AW width; the result never exceeds COLS*ROWS-1 when in_grid.
  - rd_en <= 1 only when in_grid and either (a) the tracker is invalid, or (b) the cell differs from the last fetched cell.
  - The tracker is invalidated on any cycle with in_grid=0, so the first visible pixel of every line always fetches.
  - When in_grid=0: rd_en=0 and address holds its value.
- **Capture (t+1+MEM_LAT):** rd_data_mem is captured into a char register when the matching delayed rd_en is set; otherwise the register holds. Pixels within the same cell therefore reuse one fetch.
- **Output (t+2+MEM_LAT):**
  - char_code = char register if in_grid (delayed), else 0.
  - char_valid = delayed in_grid.
  - glyph_x, glyph_y, video_on_o, hsync_o and vsync_o are delayed by the same count.
- **Total latency:** LAT = 2+MEM_LAT for all outputs, mutually aligned. The sync generator compensates by LAT.
- **Boundaries:**
  - pixel_x ≥ COLS*CELL_W or pixel_y ≥ ROWS*CELL_H with video_on=1 → char_valid=0, char_code=0, no read.
  - Bottom-right cell → address 599.
  - Cell change on consecutive cycles (CELL_W=1 is not supported) → one fetch per cell; no back-pressure exists.
  - Reset mid-line → outputs return to reset values immediately; the first in-grid pixel after release fetches unconditionally.
- **Codes:** no decoding in this block. Code 0 is the blank cell written by the buffer clear.

Optional Feature:
- CURSOR_EN defined:
  - Adds input cursor_addr[AW-1:0] and output cursor_on (1 bit, aligned with char_code, reset 0).
  - A 5-bit frame counter increments on each vsync_in falling edge (edge detected against a registered copy); it resets to 0.
  - cursor_on = delayed in_grid & (delayed address == cursor_addr) & (frame_cnt[4]==0).
  - The cursor therefore blinks with a 32-frame period, on for 16 frames.
- CURSOR_EN undefined: cursor_addr, cursor_on and the frame counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 with active stimulus → all outputs at reset values, hsync_o=vsync_o=1; release → no rd_en until in_grid.
- First cell, MEM_LAT=1, memory[0]=0x05: pixel (0,0) video_on=1 at cycle t → rd_en=1, address=0 at t+1; char_code=0x05, char_valid=1, glyph_x=0 at t+3.
- Fetch-on-change: sweep x=0..47 at y=40 → exactly 3 rd_en pulses, addresses 40, 41, 42; glyph_x cycles 0..15; char_code stable within each cell.
- Bottom-right and out-of-grid: pixel (639,479) → address 599, glyph_x=15, glyph_y=31; pixel (640,100) with video_on=1 → rd_en=0, char_valid=0, char_code=0.
- Latency sweep: MEM_LAT=3 → char_code and hsync_o edges appear exactly 5 cycles after the input; a reset pulse mid-line forces a fresh fetch at the next in-grid pixel.
- CURSOR_EN: cursor_addr=41 → cursor_on=1 only for cell (1,1) during frames 0..15; 0 during frames 16..31; returns at frame 32.

Source files
------------

// File: rtl/text_reader.sv
// text_reader: read side of the COLS x ROWS text buffer.
// Converts the sync generator's pixel position into a cell address, fetches
// each cell once when the beam enters it, and returns the character code
// aligned with delayed sync, blanking and glyph offsets.
// Total latency from pixel inputs to every output is 2 + MEM_LAT cycles.
// Optional feature: define CURSOR_EN to add a blinking cursor overlay
// (cursor_addr input, cursor_on output, 5-bit vsync frame counter).
module text_reader #(
  parameter int COLS    = 40,
  parameter int ROWS    = 15,
  parameter int CELL_W  = 16,
  parameter int CELL_H  = 32,
  parameter int MEM_LAT = 1,
  parameter int AW      = 10,
  parameter int DW      = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [9:0]                  pixel_x,
  input  logic [9:0]                  pixel_y,
  input  logic                        video_on,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  output logic [AW-1:0]               address,
  output logic                        rd_en,
  input  logic [DW-1:0]               rd_data_mem,
  output logic [DW-1:0]               char_code,
  output logic                        char_valid,
  output logic [$clog2(CELL_W)-1:0]   glyph_x,
  output logic [$clog2(CELL_H)-1:0]   glyph_y,
  output logic                        video_on_o,
  output logic                        hsync_o,
`ifdef CURSOR_EN
  input  logic [AW-1:0]               cursor_addr,
  output logic                        cursor_on,
`endif
  output logic                        vsync_o
);

  localparam int GXW = $clog2(CELL_W);
  localparam int GYW = $clog2(CELL_H);

  // Per-pixel sideband that travels with the fetch through the memory latency.
  typedef struct packed {
    logic           in_grid;
    logic           rd;
`ifdef CURSOR_EN
    logic [AW-1:0]  addr;
`endif
    logic           vid;
    logic           hs;
    logic           vs;
    logic [GXW-1:0] gx;
    logic [GYW-1:0] gy;
  } side_t;

  // Idle sideband: blanked, outside the grid, syncs inactive (high).
  function automatic side_t side_idle();
    side_t s;
    s    = '0;
    s.hs = 1'b1;
    s.vs = 1'b1;
    return s;
  endfunction

  // S0: cell coordinates of the incoming pixel
  logic [9:0]    col_s0;
  logic [9:0]    row_s0;
  logic          in_grid_s0;
  logic [AW-1:0] cell_s0;

  assign col_s0     = pixel_x >> GXW;
  assign row_s0     = pixel_y >> GYW;
  assign in_grid_s0 = video_on && (32'(col_s0) < COLS) && (32'(row_s0) < ROWS);
  assign cell_s0    = AW'(col_s0) + AW'(row_s0) * AW'(COLS);

  // S1 (p0): read request plus the registered sideband of the same pixel
  logic           in_grid_p0;
  logic           vid_p0;
  logic           hs_p0;
  logic           vs_p0;
  logic [GXW-1:0] gx_p0;
  logic [GYW-1:0] gy_p0;
  logic           trk_vld_p0;

  // Address register doubles as the last-fetched-cell tracker; trk_vld_p0
  // says whether it still describes the cell under the beam.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      address    <= '0;
      rd_en      <= 1'b0;
      trk_vld_p0 <= 1'b0;
      in_grid_p0 <= 1'b0;
      vid_p0     <= 1'b0;
      hs_p0      <= 1'b1;
      vs_p0      <= 1'b1;
      gx_p0      <= '0;
      gy_p0      <= '0;
    end else begin
      in_grid_p0 <= in_grid_s0;
      vid_p0     <= video_on;
      hs_p0      <= hsync_in;
      vs_p0      <= vsync_in;
      gx_p0      <= pixel_x[GXW-1:0];
      gy_p0      <= pixel_y[GYW-1:0];
      if (in_grid_s0) begin
        rd_en      <= !trk_vld_p0 || (cell_s0 != address);
        address    <= cell_s0;
        trk_vld_p0 <= 1'b1;
      end else begin
        rd_en      <= 1'b0;
        trk_vld_p0 <= 1'b0;
      end
    end
  end

  side_t s_p0;

  // Bundle the p0 registers so the delay line stays a single array.
  always_comb begin
    s_p0         = '0;
    s_p0.in_grid = in_grid_p0;
    s_p0.rd      = rd_en;
`ifdef CURSOR_EN
    s_p0.addr    = address;
`endif
    s_p0.vid     = vid_p0;
    s_p0.hs      = hs_p0;
    s_p0.vs      = vs_p0;
    s_p0.gx      = gx_p0;
    s_p0.gy      = gy_p0;
  end

  // p1..pN: sideband delay matching the buffer read latency
  side_t s_pn [1:MEM_LAT];
  side_t s_last;

  // Shift the sideband so stage MEM_LAT lines up with rd_data_mem.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k <= MEM_LAT; k++) s_pn[k] <= side_idle();
    end else begin
      s_pn[1] <= s_p0;
      for (int k = 2; k <= MEM_LAT; k++) s_pn[k] <= s_pn[k-1];
    end
  end

  assign s_last = s_pn[MEM_LAT];

  // Output stage: capture fresh data on a fetch, otherwise reuse the held code
  logic [DW-1:0] char_q;
  logic [DW-1:0] char_now;

  assign char_now = s_last.rd ? rd_data_mem : char_q;

  // Register every output together so they stay mutually aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      char_q     <= '0;
      char_code  <= '0;
      char_valid <= 1'b0;
      glyph_x    <= '0;
      glyph_y    <= '0;
      video_on_o <= 1'b0;
      hsync_o    <= 1'b1;
      vsync_o    <= 1'b1;
    end else begin
      char_q     <= char_now;
      char_code  <= s_last.in_grid ? char_now : '0;
      char_valid <= s_last.in_grid;
      glyph_x    <= s_last.gx;
      glyph_y    <= s_last.gy;
      video_on_o <= s_last.vid;
      hsync_o    <= s_last.hs;
      vsync_o    <= s_last.vs;
    end
  end

`ifdef CURSOR_EN
  logic       vs_q;
  logic [4:0] frame_cnt;

  // Count frames on vsync falling edges; bit 4 gates the 16-on/16-off blink.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q      <= 1'b1;
      frame_cnt <= '0;
    end else begin
      vs_q <= vsync_in;
      if (vs_q && !vsync_in) frame_cnt <= frame_cnt + 5'd1;
    end
  end

  // Cursor flag registered alongside char_code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cursor_on <= 1'b0;
    end else begin
      cursor_on <= s_last.in_grid && (s_last.addr == cursor_addr) && !frame_cnt[4];
    end
  end
`endif

endmodule
